// File: rtl/inst_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Entry layout is {pc, inst}; the NOP fills empty decode lanes.
`ifndef INST_QUEUE_DEFINES
`define INST_QUEUE_DEFINES
`define INST_QUEUE_DEPTH 8
`define NOP_INST 32'h0340_0000
`define INST_BUS_W 64
`endif

package inst_queue_pkg;

    localparam int unsigned IQ_DEPTH = `INST_QUEUE_DEPTH;
    localparam int unsigned IQ_BUS_W = `INST_BUS_W;
    localparam logic [31:0] IQ_NOP   = `NOP_INST;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    // In-order pop: lane1 only retires together with lane0.
    function automatic logic [1:0] pop_amount(
        input logic [1:0] ov,
        input logic [1:0] ordy
    );
        logic [1:0] n;
        n = 2'd0;
        if (&ordy && &ov)
            n = 2'd2;
        else if (ordy[0] && ov[0])
            n = 2'd1;
        return n;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// Entry storage: two write ports, two asynchronous read ports.
// Writers guarantee distinct addresses in the same cycle.
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             we0,
    input  logic [PTR_W-1:0] wa0,
    input  iq_entry_t        wd0,
    input  logic             we1,
    input  logic [PTR_W-1:0] wa1,
    input  iq_entry_t        wd1,
    input  logic [PTR_W-1:0] ra0,
    output iq_entry_t        rd0,
    input  logic [PTR_W-1:0] ra1,
    output iq_entry_t        rd1
);

    iq_entry_t mem [DEPTH];

    // Storage is intentionally not reset; occupancy masks stale data.
    always_ff @(posedge clk) begin
        if (we0)
            mem[wa0] <= wd0;
        if (we1)
            mem[wa1] <= wd1;
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];

endmodule

// File: rtl/inst_queue.sv
// Dual-lane FWFT instruction queue between fetch and the decode slots.
// Holds pointers, occupancy, lane compaction and flush control.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH,
    parameter int PTR_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [1:0]       in_valid,
    input  logic [31:0]      in_pc0,
    input  logic [31:0]      in_inst0,
    input  logic [31:0]      in_pc1,
    input  logic [31:0]      in_inst1,
    output logic             in_ready,
    output logic [1:0]       out_valid,
    output logic [31:0]      out_pc0,
    output logic [31:0]      out_inst0,
    output logic [31:0]      out_pc1,
    output logic [31:0]      out_inst1,
    input  logic [1:0]       out_ready,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);
    localparam logic [PTR_W:0]   RDY_LIM = (PTR_W+1)'(DEPTH - 2);
    localparam logic [PTR_W:0]   FULL    = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [1:0]       push_n;
    logic [1:0]       pop_n;
    logic             we0;
    logic             we1;
    logic [PTR_W-1:0] wa0;
    logic [PTR_W-1:0] wa1;
    iq_entry_t        wd0;
    iq_entry_t        wd1;
    iq_entry_t        rd0;
    iq_entry_t        rd1;

    assign in_ready     = (count <= RDY_LIM);
    assign out_valid[0] = (count != '0);
    assign out_valid[1] = (count >= (PTR_W+1)'(2));

    // Push decode; a lone lane1 request is compacted into the tail slot.
    always_comb begin
        we0    = 1'b0;
        we1    = 1'b0;
        wa0    = tail;
        wa1    = tail + ONE;
        wd0    = '{pc: in_pc0, inst: in_inst0};
        wd1    = '{pc: in_pc1, inst: in_inst1};
        push_n = 2'd0;
        if (in_ready && !flush) begin
            unique case (1'b1)
                (in_valid == 2'b11): begin
                    we0    = 1'b1;
                    we1    = 1'b1;
                    push_n = 2'd2;
                end
                (in_valid == 2'b01): begin
                    we0    = 1'b1;
                    push_n = 2'd1;
                end
                (in_valid == 2'b10): begin
                    we0    = 1'b1;
                    wd0    = '{pc: in_pc1, inst: in_inst1};
                    push_n = 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign pop_n = pop_amount(out_valid, out_ready);

    inst_queue_ram #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk (clk),
        .we0 (we0),
        .wa0 (wa0),
        .wd0 (wd0),
        .we1 (we1),
        .wa1 (wa1),
        .wd1 (wd1),
        .ra0 (head),
        .rd0 (rd0),
        .ra1 (head + ONE),
        .rd1 (rd1)
    );

    // Empty lanes show pc=0 and a NOP so decoders never see stale words.
    always_comb begin
        out_pc0   = 32'h0;
        out_inst0 = IQ_NOP;
        out_pc1   = 32'h0;
        out_inst1 = IQ_NOP;
        if (out_valid[0]) begin
            out_pc0   = rd0.pc;
            out_inst0 = rd0.inst;
        end
        if (out_valid[1]) begin
            out_pc1   = rd1.pc;
            out_inst1 = rd1.inst;
        end
    end

    // Pointer/occupancy update; flush drops same-cycle push and pop.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + {{(PTR_W-2){1'b0}}, pop_n};
            tail  <= tail + {{(PTR_W-2){1'b0}}, push_n};
            count <= count
                   + {{(PTR_W-1){1'b0}}, push_n}
                   - {{(PTR_W-1){1'b0}}, pop_n};
        end
    end

    // Occupancy must stay within [0, DEPTH].
    always_ff @(posedge clk) begin
        if (rst_n && !flush) begin
            assert ({{(PTR_W-1){1'b0}}, pop_n} <= count);
            assert (count <= FULL);
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Directed bench for inst_queue: vector table plus a wrap sequence.
// Outputs are sampled 1 time unit after each rising edge.
module tb_inst_queue;

    localparam logic [31:0] NOP = 32'h0340_0000;

    typedef struct {
        logic        rst_n;
        logic        flush;
        logic [1:0]  iv;
        logic [31:0] p0;
        logic [31:0] i0;
        logic [31:0] p1;
        logic [31:0] i1;
        logic [1:0]  ordy;
        logic [3:0]  cnt;
        logic        rdy;
        logic [1:0]  ov;
        logic [31:0] op0;
        logic [31:0] oi0;
        logic [31:0] op1;
        logic [31:0] oi1;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc0;
    logic [31:0] in_inst0;
    logic [31:0] in_pc1;
    logic [31:0] in_inst1;
    logic        in_ready;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic [1:0]  out_ready;
    logic [3:0]  count;

    int total;
    int bad;
    vec_t tbl[$];

    inst_queue dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_pc0    (in_pc0),
        .in_inst0  (in_inst0),
        .in_pc1    (in_pc1),
        .in_inst1  (in_inst1),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_pc0   (out_pc0),
        .out_inst0 (out_inst0),
        .out_pc1   (out_pc1),
        .out_inst1 (out_inst1),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pc(input int n);
        return 32'h1c00_0000 + 32'(4 * n);
    endfunction

    function automatic logic [31:0] ins(input int n);
        if (n == 0) return 32'h0280_0421;
        if (n == 1) return 32'h0380_0842;
        return 32'h0280_0000 | 32'(n);
    endfunction

    function automatic vec_t mk(
        input logic rs, input logic fl, input logic [1:0] iv,
        input int a, input int b, input logic [1:0] ordy,
        input int cnt, input logic rdy, input logic [1:0] ov,
        input int h0, input int h1
    );
        vec_t v;
        v.rst_n = rs;
        v.flush = fl;
        v.iv    = iv;
        v.p0    = pc(a);
        v.i0    = ins(a);
        v.p1    = pc(b);
        v.i1    = ins(b);
        v.ordy  = ordy;
        v.cnt   = 4'(cnt);
        v.rdy   = rdy;
        v.ov    = ov;
        v.op0   = ov[0] ? pc(h0) : 32'h0;
        v.oi0   = ov[0] ? ins(h0) : NOP;
        v.op1   = ov[1] ? pc(h1) : 32'h0;
        v.oi1   = ov[1] ? ins(h1) : NOP;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic drive(input vec_t v);
        rst_n     = v.rst_n;
        flush     = v.flush;
        in_valid  = v.iv;
        in_pc0    = v.p0;
        in_inst0  = v.i0;
        in_pc1    = v.p1;
        in_inst1  = v.i1;
        out_ready = v.ordy;
    endtask

    task automatic check_vec(input int k, input vec_t v);
        chk($sformatf("v%0d count", k), 32'(count), 32'(v.cnt));
        chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'(v.rdy));
        chk($sformatf("v%0d out_valid", k), 32'(out_valid), 32'(v.ov));
        chk($sformatf("v%0d out_pc0", k), out_pc0, v.op0);
        chk($sformatf("v%0d out_inst0", k), out_inst0, v.oi0);
        chk($sformatf("v%0d out_pc1", k), out_pc1, v.op1);
        chk($sformatf("v%0d out_inst1", k), out_inst1, v.oi1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        // rst fl iv a b ordy cnt rdy ov h0 h1
        tbl.push_back(mk(0, 0, 2'b00, 0, 1, 2'b00, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 1, 2'b00, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 2'b11, 0, 1, 2'b00, 2, 1, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 2'b11, 2, 3, 2'b00, 4, 1, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 2'b11, 4, 5, 2'b00, 6, 1, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 2'b11, 6, 7, 2'b00, 8, 0, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 2'b11, 20, 21, 2'b00, 8, 0, 2'b11, 0, 1));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b01, 7, 0, 2'b11, 1, 2));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b10, 7, 0, 2'b11, 1, 2));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b11, 5, 1, 2'b11, 3, 4));
        tbl.push_back(mk(1, 0, 2'b11, 8, 9, 2'b11, 5, 1, 2'b11, 5, 6));
        tbl.push_back(mk(1, 1, 2'b11, 22, 23, 2'b11, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 2'b01, 64, 0, 2'b00, 1, 1, 2'b01, 64, 0));
        tbl.push_back(mk(1, 0, 2'b10, 30, 65, 2'b00, 2, 1, 2'b11, 64, 65));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b01, 1, 1, 2'b01, 65, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b01, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 2'b00, 0, 0, 2'b11, 0, 1, 2'b00, 0, 0));
        tbl.push_back(mk(1, 0, 2'b11, 10, 11, 2'b00, 2, 1, 2'b11, 10, 11));
        tbl.push_back(mk(1, 0, 2'b01, 12, 0, 2'b00, 3, 1, 2'b11, 10, 11));
        tbl.push_back(mk(1, 0, 2'b11, 13, 14, 2'b11, 3, 1, 2'b11, 12, 13));
        tbl.push_back(mk(1, 1, 2'b00, 0, 0, 2'b00, 0, 1, 2'b00, 0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk);
            #1;
            check_vec(k, tbl[k]);
        end

        // Wrap: single lane1 pushes with one pop per cycle over 3*DEPTH.
        drive(mk(1, 0, 2'b10, 0, 100, 2'b00, 0, 1, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        chk("wrap prime count", 32'(count), 32'd1);
        chk("wrap prime pc", out_pc0, pc(100));
        for (int i = 1; i <= 24; i++) begin
            drive(mk(1, 0, 2'b10, 0, 100 + i, 2'b01, 0, 1, 2'b00, 0, 0));
            @(posedge clk);
            #1;
            chk($sformatf("wrap%0d count", i), 32'(count), 32'd1);
            chk($sformatf("wrap%0d pc", i), out_pc0, pc(100 + i));
            chk($sformatf("wrap%0d inst", i), out_inst0, ins(100 + i));
            chk($sformatf("wrap%0d valid", i), 32'(out_valid), 32'd1);
        end

        // Drain the last entry, then reset mid-stream.
        drive(mk(1, 0, 2'b00, 0, 0, 2'b01, 0, 1, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        chk("drain count", 32'(count), 32'd0);
        drive(mk(1, 0, 2'b11, 40, 41, 2'b00, 0, 1, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        chk("refill count", 32'(count), 32'd2);
        chk("refill pc1", out_pc1, pc(41));
        drive(mk(0, 0, 2'b11, 42, 43, 2'b11, 0, 1, 2'b00, 0, 0));
        @(posedge clk);
        #1;
        chk("rst count", 32'(count), 32'd0);
        chk("rst inst0", out_inst0, NOP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
